// File: rtl/data_sram_response_if.sv
// Data SRAM response channel plus MEM-stage load context, as seen by the MEM-stage consumer.
// The slave modport is the consumer; the master modport is whoever drives the pipeline side.
interface data_sram_response_if;
  logic        req_fire_EX;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        EX_MEM_reg_valid;
  logic        mem_en_MEM;
  logic        mem_wen_MEM;
  logic        mem_w_MEM;
  logic        mem_h_MEM;
  logic        mem_hu_MEM;
  logic        mem_b_MEM;
  logic        mem_bu_MEM;
  logic        mem_wl_MEM;
  logic        mem_wr_MEM;
  logic [1:0]  byte_offset_MEM;
  logic [31:0] rt_old_MEM;
  logic        MEM_WB_reg_allow_in;
  logic        flush;
  logic [31:0] load_data_MEM;
  logic        mem_done_MEM;
  logic        EX_MEM_reg_stall_mem_not_ready;
  logic        outstanding_overflow;

  modport slave (
    input  req_fire_EX, data_sram_data_ok, data_sram_rdata, EX_MEM_reg_valid,
    input  mem_en_MEM, mem_wen_MEM, mem_w_MEM, mem_h_MEM, mem_hu_MEM, mem_b_MEM,
    input  mem_bu_MEM, mem_wl_MEM, mem_wr_MEM, byte_offset_MEM, rt_old_MEM,
    input  MEM_WB_reg_allow_in, flush,
    output load_data_MEM, mem_done_MEM, EX_MEM_reg_stall_mem_not_ready, outstanding_overflow
  );

  modport master (
    output req_fire_EX, data_sram_data_ok, data_sram_rdata, EX_MEM_reg_valid,
    output mem_en_MEM, mem_wen_MEM, mem_w_MEM, mem_h_MEM, mem_hu_MEM, mem_b_MEM,
    output mem_bu_MEM, mem_wl_MEM, mem_wr_MEM, byte_offset_MEM, rt_old_MEM,
    output MEM_WB_reg_allow_in, flush,
    input  load_data_MEM, mem_done_MEM, EX_MEM_reg_stall_mem_not_ready, outstanding_overflow
  );
endinterface

// File: rtl/data_sram_response.sv
// MEM-stage data SRAM response consumer: in-flight tracking, flush discard, one-entry
// response buffer, and little-endian load alignment/extension for WB.
module data_sram_response #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_sram_response_if.slave  bus
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] MaxCnt = (CW + 1)'(MAX_OUTSTANDING);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_discard_cnt;
  logic          r_buf_valid;
  logic [31:0]   r_buf_data;
  logic          r_overflow;

  logic          w_mem_op;
  logic          w_discarding;
  logic          w_live_ok;
  logic [CW:0]   w_sum;
  logic [CW:0]   w_cnt_raw;
  logic          w_cnt_over;
  logic          w_underflow;
  logic [CW-1:0] w_cnt_next;
  logic          w_done;
  logic          w_buf_set;
  logic          w_buf_clr;
  logic          w_proto_err;
  logic [31:0]   w_raw;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign w_mem_op     = bus.EX_MEM_reg_valid & (bus.mem_en_MEM | bus.mem_wen_MEM);
  assign w_discarding = r_discard_cnt != '0;
  assign w_live_ok    = bus.data_sram_data_ok & ~w_discarding;

  assign w_sum       = {1'b0, r_cnt} + {{CW{1'b0}}, bus.req_fire_EX};
  assign w_underflow = bus.data_sram_data_ok & (r_cnt == '0);

  // A response with nothing in flight is an error; the count floors at zero.
  always_comb begin
    w_cnt_raw = w_sum;
    if (bus.data_sram_data_ok && (w_sum != '0)) begin
      w_cnt_raw = w_sum - 1'b1;
    end
  end

  assign w_cnt_over = w_cnt_raw > MaxCnt;
  assign w_cnt_next = w_cnt_over ? MaxCnt[CW-1:0] : w_cnt_raw[CW-1:0];

  assign w_done      = w_mem_op & (r_buf_valid | w_live_ok);
  assign w_buf_set   = w_live_ok & w_mem_op & ~bus.MEM_WB_reg_allow_in & ~bus.flush;
  assign w_buf_clr   = (w_mem_op & w_done & bus.MEM_WB_reg_allow_in) | bus.flush;
  assign w_proto_err = w_live_ok & r_buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_discard_cnt <= '0;
      r_buf_valid   <= 1'b0;
      r_buf_data    <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_cnt_over || w_underflow || w_proto_err) begin
        r_overflow <= 1'b1;
      end
      // Everything still in flight after a flush belongs to killed instructions.
      if (bus.flush) begin
        r_discard_cnt <= w_cnt_next;
      end else if (bus.data_sram_data_ok && w_discarding) begin
        r_discard_cnt <= r_discard_cnt - 1'b1;
      end
      if (w_buf_clr) begin
        r_buf_valid <= 1'b0;
      end else if (w_buf_set) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= bus.data_sram_rdata;
      end
    end
  end

  assign w_raw  = r_buf_valid ? r_buf_data : bus.data_sram_rdata;
  assign w_half = bus.byte_offset_MEM[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_byte = w_raw[7:0];
    case (bus.byte_offset_MEM)
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  always_comb begin
    w_load = '0;
    if (w_done && bus.mem_en_MEM) begin
      if (bus.mem_w_MEM) begin
        w_load = w_raw;
      end else if (bus.mem_h_MEM) begin
        w_load = {{16{w_half[15]}}, w_half};
      end else if (bus.mem_hu_MEM) begin
        w_load = {16'h0000, w_half};
      end else if (bus.mem_b_MEM) begin
        w_load = {{24{w_byte[7]}}, w_byte};
      end else if (bus.mem_bu_MEM) begin
        w_load = {24'h000000, w_byte};
      end else if (bus.mem_wl_MEM) begin
        case (bus.byte_offset_MEM)
          2'd0:    w_load = {w_raw[7:0], bus.rt_old_MEM[23:0]};
          2'd1:    w_load = {w_raw[15:0], bus.rt_old_MEM[15:0]};
          2'd2:    w_load = {w_raw[23:0], bus.rt_old_MEM[7:0]};
          default: w_load = w_raw;
        endcase
      end else if (bus.mem_wr_MEM) begin
        case (bus.byte_offset_MEM)
          2'd0:    w_load = w_raw;
          2'd1:    w_load = {bus.rt_old_MEM[31:24], w_raw[31:8]};
          2'd2:    w_load = {bus.rt_old_MEM[31:16], w_raw[31:16]};
          default: w_load = {bus.rt_old_MEM[31:8], w_raw[31:24]};
        endcase
      end
    end
  end

  assign bus.load_data_MEM                  = w_load;
  assign bus.mem_done_MEM                   = w_done;
  assign bus.EX_MEM_reg_stall_mem_not_ready = w_mem_op & ~w_done & ~bus.flush;
  assign bus.outstanding_overflow           = r_overflow;
endmodule

// File: tb/tb_data_sram_response.sv
// Self-checking bench for data_sram_response: vector table, randomized loads against a
// byte-level reference model, and hand-written buffer/flush/overflow sequences.
module tb_data_sram_response;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  data_sram_response_if bus ();

  data_sram_response #(.MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Load kinds: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 lwl, 6 lwr, 7 store
  typedef struct {
    int          t;
    int          off;
    int          lat;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.req_fire_EX         = 1'b0;
    bus.data_sram_data_ok   = 1'b0;
    bus.data_sram_rdata     = 32'h0;
    bus.EX_MEM_reg_valid    = 1'b0;
    bus.mem_en_MEM          = 1'b0;
    bus.mem_wen_MEM         = 1'b0;
    bus.mem_w_MEM           = 1'b0;
    bus.mem_h_MEM           = 1'b0;
    bus.mem_hu_MEM          = 1'b0;
    bus.mem_b_MEM           = 1'b0;
    bus.mem_bu_MEM          = 1'b0;
    bus.mem_wl_MEM          = 1'b0;
    bus.mem_wr_MEM          = 1'b0;
    bus.byte_offset_MEM     = 2'd0;
    bus.rt_old_MEM          = 32'h0;
    bus.MEM_WB_reg_allow_in = 1'b1;
    bus.flush               = 1'b0;
  endtask

  task automatic set_mem(input int t, input int off, input logic [31:0] rt);
    bus.EX_MEM_reg_valid = 1'b1;
    bus.mem_en_MEM       = (t != 7);
    bus.mem_wen_MEM      = (t == 7);
    bus.mem_w_MEM        = (t == 0);
    bus.mem_h_MEM        = (t == 1);
    bus.mem_hu_MEM       = (t == 2);
    bus.mem_b_MEM        = (t == 3);
    bus.mem_bu_MEM       = (t == 4);
    bus.mem_wl_MEM       = (t == 5);
    bus.mem_wr_MEM       = (t == 6);
    bus.byte_offset_MEM  = 2'(off);
    bus.rt_old_MEM       = rt;
  endtask

  // Reference: treat the word as bytes in little-endian order and merge by byte counts.
  function automatic logic [31:0] ref_load(input int t, input int off, input logic [31:0] rt,
                                           input logic [31:0] raw);
    logic [31:0] ones;
    logic [31:0] sh;
    ones = 32'hFFFF_FFFF;
    case (t)
      0: return raw;
      1: begin sh = raw >> (16 * (off / 2)); return 32'($signed(sh[15:0])); end
      2: begin sh = raw >> (16 * (off / 2)); return {16'h0, sh[15:0]}; end
      3: begin sh = raw >> (8 * off); return 32'($signed(sh[7:0])); end
      4: begin sh = raw >> (8 * off); return {24'h0, sh[7:0]}; end
      5: return (raw << (8 * (3 - off))) | (rt & ~(ones << (8 * (3 - off))));
      6: return (raw >> (8 * off)) | (rt & ~(ones >> (8 * off)));
      default: return 32'h0;
    endcase
  endfunction

  // Fire in EX, sit in MEM stalled for lat cycles, then take data_ok with WB accepting.
  task automatic do_load(input string name, input int t, input int off, input int lat,
                         input logic [31:0] rt, input logic [31:0] rdata,
                         input logic [31:0] exp);
    idle();
    bus.req_fire_EX = 1'b1;
    settle();
    check({name, "_fire_stall"}, 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd0);
    step();
    bus.req_fire_EX = 1'b0;
    set_mem(t, off, rt);
    for (int i = 0; i < lat; i++) begin
      settle();
      check({name, "_wait_stall"}, 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd1);
      check({name, "_wait_done"}, 32'(bus.mem_done_MEM), 32'd0);
      step();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = rdata;
    settle();
    check({name, "_done"}, 32'(bus.mem_done_MEM), 32'd1);
    check({name, "_stall"}, 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd0);
    check({name, "_data"}, bus.load_data_MEM, exp);
    step();
    idle();
  endtask

  initial begin
    int t;
    int off;
    int lat;
    logic [31:0] rt;
    logic [31:0] rd;

    n_tests = 0;
    n_fail  = 0;
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    settle();
    check("rst_done", 32'(bus.mem_done_MEM), 32'd0);
    check("rst_stall", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd0);
    check("rst_data", bus.load_data_MEM, 32'd0);
    check("rst_ovf", 32'(bus.outstanding_overflow), 32'd0);
    step();

    vecs[0] = '{0, 0, 3, 32'h0,        32'h8899AABB, 32'h8899AABB};
    vecs[1] = '{3, 3, 1, 32'h0,        32'h80112233, 32'hFFFFFF80};
    vecs[2] = '{4, 3, 0, 32'h0,        32'h80112233, 32'h00000080};
    vecs[3] = '{1, 2, 2, 32'h0,        32'h80112233, 32'hFFFF8011};
    vecs[4] = '{2, 2, 0, 32'h0,        32'h80112233, 32'h00008011};
    vecs[5] = '{5, 1, 1, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344};
    vecs[6] = '{6, 2, 1, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB};
    vecs[7] = '{5, 0, 0, 32'h11223344, 32'hAABBCCDD, 32'hDD223344};
    vecs[8] = '{6, 3, 0, 32'h11223344, 32'hAABBCCDD, 32'h112233AA};
    vecs[9] = '{7, 0, 1, 32'h0,        32'h55555555, 32'h00000000};
    for (int i = 0; i < 10; i++) begin
      do_load($sformatf("vec%0d", i), vecs[i].t, vecs[i].off, vecs[i].lat, vecs[i].rt,
              vecs[i].rdata, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      t   = int'($urandom_range(0, 7));
      off = (t == 1 || t == 2) ? 2 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      lat = int'($urandom_range(0, 3));
      rt  = $urandom;
      rd  = $urandom;
      do_load($sformatf("rnd%0d_t%0d_o%0d", i, t, off), t, off, lat, rt, rd,
              ref_load(t, off, rt, rd));
    end
    settle();
    check("rnd_no_ovf", 32'(bus.outstanding_overflow), 32'd0);
    step();

    // Response arrives while WB is blocked; buffered copy must survive rdata changing.
    idle();
    bus.req_fire_EX = 1'b1;
    step();
    idle();
    set_mem(0, 0, 32'h0);
    bus.MEM_WB_reg_allow_in = 1'b0;
    bus.data_sram_data_ok   = 1'b1;
    bus.data_sram_rdata     = 32'h12345678;
    settle();
    check("buf_arrive", bus.load_data_MEM, 32'h12345678);
    step();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'hBADBAD00;
    settle();
    check("buf_hold_done", 32'(bus.mem_done_MEM), 32'd1);
    check("buf_hold_stall", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd0);
    check("buf_hold_data", bus.load_data_MEM, 32'h12345678);
    step();
    bus.MEM_WB_reg_allow_in = 1'b1;
    settle();
    check("buf_release", bus.load_data_MEM, 32'h12345678);
    step();
    set_mem(0, 0, 32'h0);
    settle();
    check("buf_cleared_stall", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd1);
    step();
    idle();

    // Flush with two requests in flight; both responses must be dropped.
    bus.req_fire_EX = 1'b1;
    step();
    bus.req_fire_EX = 1'b1;
    step();
    bus.req_fire_EX = 1'b0;
    set_mem(0, 0, 32'h0);
    bus.flush = 1'b1;
    settle();
    check("flush_stall", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd0);
    step();
    bus.flush             = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hDEAD0001;
    settle();
    check("drop1_done", 32'(bus.mem_done_MEM), 32'd0);
    check("drop1_data", bus.load_data_MEM, 32'd0);
    step();
    bus.req_fire_EX     = 1'b1;
    bus.data_sram_rdata = 32'hDEAD0002;
    settle();
    check("drop2_done", 32'(bus.mem_done_MEM), 32'd0);
    check("drop2_stall", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd1);
    step();
    bus.req_fire_EX       = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    settle();
    check("post_flush_wait", 32'(bus.EX_MEM_reg_stall_mem_not_ready), 32'd1);
    step();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000CAFE;
    settle();
    check("post_flush_done", 32'(bus.mem_done_MEM), 32'd1);
    check("post_flush_data", bus.load_data_MEM, 32'h0000CAFE);
    step();
    idle();
    settle();
    check("flush_no_ovf", 32'(bus.outstanding_overflow), 32'd0);
    step();

    // Back-to-back: next fire overlaps the previous response.
    bus.req_fire_EX = 1'b1;
    step();
    set_mem(0, 0, 32'h0);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h11111111;
    settle();
    check("b2b_a", bus.load_data_MEM, 32'h11111111);
    step();
    bus.req_fire_EX     = 1'b0;
    bus.data_sram_rdata = 32'h22222222;
    settle();
    check("b2b_b", bus.load_data_MEM, 32'h22222222);
    step();
    idle();
    settle();
    check("b2b_no_ovf", 32'(bus.outstanding_overflow), 32'd0);
    step();

    // Third outstanding request exceeds the limit of two.
    bus.req_fire_EX = 1'b1;
    step();
    step();
    settle();
    check("two_out_no_ovf", 32'(bus.outstanding_overflow), 32'd0);
    step();
    idle();
    settle();
    check("ovf_set", 32'(bus.outstanding_overflow), 32'd1);
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check("rst2_ovf", 32'(bus.outstanding_overflow), 32'd0);
    check("rst2_done", 32'(bus.mem_done_MEM), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/data_sram_response.md
Name: data_sram_response

Overview:
- MEM-stage consumer of the data SRAM response channel.
- Tracks in-flight data requests issued from EX and drops responses that belong to flushed instructions.
- Buffers rdata while MEM is stalled by WB, stalls MEM until its own response arrives, and produces the aligned and extended load result (lw/lh/lhu/lb/lbu/lwl/lwr, little-endian) for WB.

Parameters:
MAX_OUTSTANDING, 2, maximum in-flight requests; counter width is clog2(MAX_OUTSTANDING+1).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req_fire_EX  in  1  data_sram_req & data_sram_addr_ok this cycle.
data_sram_data_ok  in  1  response handshake; one pulse per accepted request, in order.
data_sram_rdata  in  32  read data; valid when data_ok=1.
EX_MEM_reg_valid  in  1  MEM stage holds a valid instruction.
mem_en_MEM  in  1  MEM instruction is a load.
mem_wen_MEM  in  1  MEM instruction is a store.
mem_w_MEM, mem_h_MEM, mem_hu_MEM, mem_b_MEM, mem_bu_MEM, mem_wl_MEM, mem_wr_MEM  in  1 each  one-hot load type.
byte_offset_MEM  in  2  address bits [1:0] of the MEM access.
rt_old_MEM  in  32  old rt value, merged by lwl/lwr.
MEM_WB_reg_allow_in  in  1  WB accepts the MEM instruction this cycle.
flush  in  1  exception/eret; kills the instructions in EX and MEM this cycle.
load_data_MEM  out  32  aligned load result.
mem_done_MEM  out  1  the MEM access has its response (buffered or arriving now).
EX_MEM_reg_stall_mem_not_ready  out  1  stall MEM: waiting for data_ok.
outstanding_overflow  out  1  sticky error flag for the bench.

Behaviour:
- Reset:
  - outstanding count cnt=0, discard_cnt=0, buf_valid=0, buf_data=0, outstanding_overflow=0.
  - Outputs derived from this state: mem_done_MEM=0, stall=0, load_data_MEM=0.
- Definitions:
  - mem_op = EX_MEM_reg_valid & (mem_en_MEM | mem_wen_MEM).
  - discarding = discard_cnt != 0.
  - live_ok = data_ok & ~discarding.
- Outstanding count: cnt_next = cnt + req_fire_EX - data_ok, all bits combined in one cycle, so a simultaneous fire and ok leave cnt unchanged.
  - cnt_next > MAX_OUTSTANDING sets outstanding_overflow; cnt saturates.
  - data_ok with cnt=0 also sets outstanding_overflow; cnt stays 0.
- Discard:
  - On flush, discard_cnt <= cnt + req_fire_EX - (data_ok & ~discarding) - (data_ok & discarding), i.e. every request still in flight after this cycle is marked for discard.
  - Without flush, data_ok while discarding decrements discard_cnt. That data never reaches buf or load_data.
- Response buffer (one entry):
  - Set when live_ok & mem_op & ~(MEM_WB_reg_allow_in) & ~flush: buf_valid<=1, buf_data<=rdata.
  - Cleared when mem_op & mem_done_MEM & MEM_WB_reg_allow_in (instruction leaves MEM), or on flush. Flush has priority over set.
  - live_ok while buf_valid=1 is a protocol error; set outstanding_overflow.
- mem_done_MEM = mem_op & (buf_valid | live_ok).
- EX_MEM_reg_stall_mem_not_ready = mem_op & ~mem_done_MEM & ~flush. The response is used combinationally in its arrival cycle (zero extra latency).
- Data source: raw = buf_valid ? buf_data : data_sram_rdata. Byte k means raw[8k+7:8k], with k = byte_offset.
- Load result for each type:
  - w: raw.
  - b/bu: byte k, sign- or zero-extended.
  - h/hu: halfword at offset 0 or 2, sign- or zero-extended. Offsets 1 and 3 never reach here; they are unaligned and excepted in EX.
  - lwl: off0 {raw[7:0],rt[23:0]}; off1 {raw[15:0],rt[15:0]}; off2 {raw[23:0],rt[7:0]}; off3 raw.
  - lwr: off0 raw; off1 {rt[31:24],raw[31:8]}; off2 {rt[31:16],raw[31:16]}; off3 {rt[31:8],raw[31:24]}.
  - Stores, and the case ~mem_done_MEM: load_data_MEM=0.
- Reset mid-operation: all state cleared. Responses to pre-reset requests are not tracked; the SRAM side is reset together with the block.

Test Plan:
- Aligned lw, data_ok 3 cycles after fire, rdata=0x8899AABB: stall=1 for 3 cycles, then mem_done=1 and load_data=0x8899AABB in the data_ok cycle; cnt returns to 0.
- lb offset 3, rdata=0x80112233 -> 0xFFFFFF80; lbu -> 0x00000080; lh offset 2 -> 0xFFFF8011; lhu -> 0x00008011.
- lwl offset 1 and lwr offset 2, rt=0x11223344, rdata=0xAABBCCDD -> lwl 0xCCDD3344, lwr 0x1122AABB.
- data_ok arrives while MEM_WB_reg_allow_in=0 for 2 cycles, rdata=0x12345678 -> buf_valid=1, data_sram_rdata then changes to garbage, load_data stays 0x12345678 and is released when allow_in=1.
- Flush with cnt=2 -> discard_cnt=2; the next two data_ok pulses (rdata 0xDEAD0001, 0xDEAD0002) are dropped. A new lw fired after that gets 3rd data_ok with 0x0000CAFE, delivered as 0x0000CAFE.
- Simultaneous req_fire_EX and data_ok for back-to-back loads: cnt stays 1, no overflow. A third fire with cnt=2 sets outstanding_overflow.
